load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_if.sv | 25 ++
 rtl/lsu_load_ext.sv | 21 ++
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 tb/tb_load_store_unit.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states
// and the alignment helper used when LSU_MISALIGN_TRAP_EN is defined.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StCapture,
        StResp
    } lsu_state_e;

    function automatic logic lsu_misaligned(logic [1:0] size, logic [1:0] addr_lo);
        return ((size == SZ_HALF) && addr_lo[0]) ||
               ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response handshake of the load/store unit.
// master = core, slave = load_store_unit.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_load_ext.sv
// Load data extension: picks the low byte/half/word of the BRAM read data
// and sign- or zero-extends it to 32 bits.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] dout_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] rdata_o
);

    always_comb begin
        rdata_o = dout_i;
        case (size_i)
            SZ_BYTE: rdata_o = {{24{~unsigned_i & dout_i[7]}}, dout_i[7:0]};
            SZ_HALF: rdata_o = {{16{~unsigned_i & dout_i[15]}}, dout_i[15:0]};
            default: rdata_o = dout_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging a core request port to a BRAM
// with registered read data. Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    lsu_if.slave              bus,
    output logic              mem_wen,
    output logic              mem_b,
    output logic              mem_h,
    output logic              mem_u,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              mem_wen_q, mem_wen_d;
    logic              mem_b_q, mem_b_d;
    logic              mem_h_q, mem_h_d;
    logic              mem_u_q, mem_u_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_din_q, mem_din_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;

    logic              req_err;
    logic [31:0]       ext_rdata;

    // Requests outside the BRAM window or with the reserved size never touch memory.
    always_comb begin
        req_err = (bus.req_size == SZ_ILL) || (|bus.req_addr[31:MEM_AW]);
`ifdef LSU_MISALIGN_TRAP_EN
        req_err = req_err || lsu_misaligned(bus.req_size, bus.req_addr[1:0]);
`endif
    end

    lsu_load_ext u_load_ext (
        .dout_i    (mem_dout),
        .size_i    (size_q),
        .unsigned_i(uns_q),
        .rdata_o   (ext_rdata)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        mem_wen_d    = 1'b0;
        mem_b_d      = mem_b_q;
        mem_h_d      = mem_h_q;
        mem_u_d      = mem_u_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    we_d   = bus.req_we;
                    size_d = bus.req_size;
                    uns_d  = bus.req_unsigned;
                    if (req_err) begin
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        // Memory outputs are set up here so they are registered in ACCESS.
                        state_d    = StAccess;
                        mem_wen_d  = bus.req_we;
                        mem_addr_d = bus.req_addr[MEM_AW-1:0];
                        mem_b_d    = (bus.req_size == SZ_BYTE);
                        mem_h_d    = (bus.req_size == SZ_HALF);
                        mem_u_d    = bus.req_unsigned;
                        mem_din_d  = bus.req_wdata;
                    end
                end
            end
            StAccess: begin
                if (we_q) begin
                    state_d      = StResp;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                end else begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                state_d      = StResp;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = ext_rdata;
            end
            StResp: begin
                if (bus.resp_ready) begin
                    state_d      = StIdle;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_b_q      <= 1'b0;
            mem_h_q      <= 1'b0;
            mem_u_q      <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            mem_wen_q    <= mem_wen_d;
            mem_b_q      <= mem_b_d;
            mem_h_q      <= mem_h_d;
            mem_u_q      <= mem_u_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;

    assign mem_wen  = mem_wen_q;
    assign mem_b    = mem_b_q;
    assign mem_h    = mem_h_q;
    assign mem_u    = mem_u_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed BRAM model and a
// scoreboard queue of expected responses.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        mem_wen, mem_b, mem_h, mem_u;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];

    logic [7:0] ram [1024];

    lsu_if bus ();

    load_store_unit #(
        .MEM_AW(10)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .mem_wen (mem_wen),
        .mem_b   (mem_b),
        .mem_h   (mem_h),
        .mem_u   (mem_u),
        .mem_addr(mem_addr),
        .mem_din (mem_din),
        .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: little-endian byte array, read data registered one cycle.
    always @(posedge clk) begin
        logic [9:0] a1, a2, a3;
        a1 = mem_addr + 10'd1;
        a2 = mem_addr + 10'd2;
        a3 = mem_addr + 10'd3;
        if (mem_wen) begin
            ram[mem_addr] <= mem_din[7:0];
            if (!mem_b) ram[a1] <= mem_din[15:8];
            if (!mem_b && !mem_h) begin
                ram[a2] <= mem_din[23:16];
                ram[a3] <= mem_din[31:24];
            end
        end
        mem_dout <= {ram[a3], ram[a2], ram[a1], ram[mem_addr]};
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string name, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input int hold);
        exp_t e;
        logic acc;
        int   lat;
        int   wen_cnt;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        sb.push_back(e);
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({name, "_accept"}, {31'd0, acc}, 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat     = 0;
        wen_cnt = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (mem_wen === 1'b1) wen_cnt++;
            if (n == 1 && !exp_err) begin
                chk({name, "_mem_addr"}, {22'd0, mem_addr}, {22'd0, addr[9:0]});
                chk({name, "_mem_b"}, {31'd0, mem_b}, {31'd0, size == 2'b00});
                chk({name, "_mem_h"}, {31'd0, mem_h}, {31'd0, size == 2'b01});
                chk({name, "_mem_u"}, {31'd0, mem_u}, {31'd0, uns});
                chk({name, "_mem_wen"}, {31'd0, mem_wen}, {31'd0, we});
                if (we) chk({name, "_mem_din"}, mem_din, wdata);
            end
            if (bus.resp_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk({name, "_latency"}, lat, exp_lat);
        e = sb.pop_front();
        if (lat != 0) begin
            for (int h = 0; h < hold; h++) begin
                chk({name, "_hold_valid"}, {31'd0, bus.resp_valid}, 32'd1);
                chk({name, "_hold_rdata"}, bus.resp_rdata, e.rdata);
                chk({name, "_hold_req_ready"}, {31'd0, bus.req_ready}, 32'd0);
                @(negedge clk);
                if (mem_wen === 1'b1) wen_cnt++;
            end
            chk({name, "_rdata"}, bus.resp_rdata, e.rdata);
            chk({name, "_err"}, {31'd0, bus.resp_err}, {31'd0, e.err});
            bus.resp_ready = 1'b1;
            @(posedge clk);
            #1 bus.resp_ready = 1'b0;
            @(negedge clk);
            chk({name, "_valid_drop"}, {31'd0, bus.resp_valid}, 32'd0);
        end
        chk({name, "_wen_count"}, wen_cnt, (we && !exp_err) ? 1 : 0);
    endtask

    initial begin
        int seen;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.resp_ready   = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
        chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst_mem_din", mem_din, 32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        rst = 1'b0;

        do_req("st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0);
        do_req("ld_w10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);
        do_req("st_w20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h00000080, 32'h0, 1'b0, 2, 0);
        do_req("ld_bs", 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'hFFFFFF80, 1'b0, 3, 0);
        do_req("ld_bu", 1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'h00000080, 1'b0, 3, 0);
        do_req("st_w30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h00008001, 32'h0, 1'b0, 2, 0);
        do_req("ld_hs_hold", 1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 32'hFFFF8001, 1'b0, 3, 5);
        do_req("ld_hu", 1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 32'h00008001, 1'b0, 3, 0);
        do_req("err_oor", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1, 0);
        do_req("err_size", 1'b1, 2'b11, 1'b0, 32'h40, 32'h12345678, 32'h0, 1'b1, 1, 0);
        do_req("st_w14", 1'b1, 2'b10, 1'b0, 32'h14, 32'h11223344, 32'h0, 1'b0, 2, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        do_req("ld_mis13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0);
`else
        do_req("ld_mis13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h223344DE, 1'b0, 3, 0);
`endif

        // Reset while the load sits in CAPTURE; the response must never appear.
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h10;
        chk("rstcap_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rstcap_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rstcap_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rstcap_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rstcap_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rstcap_mem_wen", {31'd0, mem_wen}, 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0) seen++;
        end
        chk("rstcap_no_resp", seen, 0);

        do_req("ld_after_rst", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
